// File: rtl/pslip_grant_arb.sv
// pslip_grant_arb: registers a pSLIP request vector, grants one requester round-robin, holds the grant until accept/reject/timeout
module pslip_grant_arb #(
    parameter int N       = 4,
    parameter int P       = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [$clog2(P)-1:0] pri,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic [N-1:0]         gnt,
    output logic [$clog2(P)-1:0] gnt_pri,
    output logic                 gnt_valid,
    input  logic                 acc,
    input  logic                 rej,
    output logic [$clog2(N)-1:0] ptr,
    output logic                 timeout_pulse
);
    localparam int NW = $clog2(N);
    localparam int PW = $clog2(P);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   ptr_q, ptr_d, idx_q, idx_d, sel;
    logic [PW-1:0]   pri_q, pri_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tp_q, tp_d, hit;

    assign req_ready     = state_q == IDLE;
    assign gnt_valid     = state_q == GRANT;
    assign gnt           = gnt_valid ? N'(1) << idx_q : '0;
    assign gnt_pri       = pri_q;
    assign ptr           = ptr_q;
    assign timeout_pulse = tp_q;

    // first requester at or above the pointer, wrapping modulo N
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!hit && req[(int'(ptr_q) + j) % N]) begin
                hit = 1'b1;
                sel = NW'((int'(ptr_q) + j) % N);
            end
        end
    end

    // next state: latch a grant from IDLE, close it on accept, reject or timeout
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        pri_d   = pri_q;
        cnt_d   = cnt_q;
        tp_d    = 1'b0;
        if (state_q == IDLE) begin
            if (req_valid && hit) begin
                state_d = GRANT;
                idx_d   = sel;
                pri_d   = pri;
                cnt_d   = '0;
            end
        end else if (acc) begin
            state_d = IDLE;
            ptr_d   = idx_q == NW'(N - 1) ? '0 : idx_q + 1'b1;
        end else if (rej) begin
            state_d = IDLE;
        end else if (TIMEOUT > 0 && cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            tp_d    = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            pri_q   <= '0;
            cnt_q   <= '0;
            tp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            pri_q   <= pri_d;
            cnt_q   <= cnt_d;
            tp_q    <= tp_d;
        end
    end
endmodule

// File: tb/tb_pslip_grant_arb.sv
// tb_pslip_grant_arb: directed scenarios plus randomized run against a behavioural model
module tb_pslip_grant_arb;
    localparam int N = 4;
    localparam int P = 16;
    localparam int TIMEOUT = 8;

    logic       clk = 0, reset = 1, req_valid = 0, acc = 0, rej = 0;
    logic [3:0] req = 0, pri = 0;
    logic       req_ready, gnt_valid, timeout_pulse;
    logic [3:0] gnt, gnt_pri;
    logic [1:0] ptr;
    int checks = 0, failures = 0;

    pslip_grant_arb #(.N(N), .P(P), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .pri(pri), .req_valid(req_valid),
        .req_ready(req_ready), .gnt(gnt), .gnt_pri(gnt_pri), .gnt_valid(gnt_valid),
        .acc(acc), .rej(rej), .ptr(ptr), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] r, input logic [3:0] p);
        req = r; pri = p; req_valid = 1;
        cyc();
        req_valid = 0;
    endtask

    function automatic int search(input logic [3:0] r, input int p);
        for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
        return -1;
    endfunction

    task automatic test_reset;
        reset = 1;
        cyc(); cyc();
        reset = 0;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_gnt_valid got=%b exp=0", gnt_valid); end
        checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (timeout_pulse !== 1'b0 || gnt_pri !== 4'd0) begin failures++; $display("FAIL reset_misc tp=%b pri=%0d exp 0/0", timeout_pulse, gnt_pri); end
    endtask

    task automatic test_basic;
        offer(4'b1010, 4'd7);
        checks++; if (gnt !== 4'b0010 || gnt_pri !== 4'd7 || gnt_valid !== 1'b1) begin failures++; $display("FAIL basic_gnt got=%b/%0d/%b exp=0010/7/1", gnt, gnt_pri, gnt_valid); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL basic_ready got=%b exp=0", req_ready); end
        acc = 1; cyc(); acc = 0;
        checks++; if (ptr !== 2'd2 || gnt !== 4'b0000 || gnt_valid !== 1'b0) begin failures++; $display("FAIL basic_acc ptr=%0d gnt=%b v=%b exp 2/0000/0", ptr, gnt, gnt_valid); end
        offer(4'b1010, 4'd7);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL basic_gnt2 got=%b exp=1000", gnt); end
        acc = 1; cyc(); acc = 0;
        checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL basic_wrap_ptr got=%0d exp=0", ptr); end
    endtask

    task automatic test_wrap_search;
        offer(4'b0010, 4'd1);
        acc = 1; cyc(); acc = 0;
        checks++; if (ptr !== 2'd2) begin failures++; $display("FAIL ws_setup_ptr got=%0d exp=2", ptr); end
        for (int i = 0; i < 2; i++) begin
            offer(4'b0011, 4'd3);
            checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL ws_gnt%0d got=%b exp=0001", i, gnt); end
            rej = 1; cyc(); rej = 0;
            checks++; if (ptr !== 2'd2 || gnt_valid !== 1'b0) begin failures++; $display("FAIL ws_rej%0d ptr=%0d v=%b exp 2/0", i, ptr, gnt_valid); end
        end
    endtask

    task automatic test_timeout;
        offer(4'b0100, 4'd9);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL to_gnt got=%b exp=0100", gnt); end
        for (int i = 2; i <= TIMEOUT; i++) begin
            cyc();
            checks++; if (gnt_valid !== 1'b1 || timeout_pulse !== 1'b0) begin failures++; $display("FAIL to_hold cyc%0d v=%b tp=%b exp 1/0", i, gnt_valid, timeout_pulse); end
        end
        cyc();
        checks++; if (timeout_pulse !== 1'b1 || gnt_valid !== 1'b0 || ptr !== 2'd2) begin failures++; $display("FAIL to_fire tp=%b v=%b ptr=%0d exp 1/0/2", timeout_pulse, gnt_valid, ptr); end
        cyc();
        checks++; if (timeout_pulse !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", timeout_pulse); end
    endtask

    task automatic test_acc_timeout;
        offer(4'b0100, 4'd9);
        for (int i = 2; i <= TIMEOUT; i++) cyc();
        acc = 1; cyc(); acc = 0;
        checks++; if (timeout_pulse !== 1'b0 || ptr !== 2'd3 || gnt_valid !== 1'b0) begin failures++; $display("FAIL acc_to tp=%b ptr=%0d v=%b exp 0/3/0", timeout_pulse, ptr, gnt_valid); end
    endtask

    task automatic test_both_and_zero;
        offer(4'b0100, 4'd15);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL both_gnt got=%b exp=0100", gnt); end
        acc = 1; rej = 1; cyc(); acc = 0; rej = 0;
        checks++; if (ptr !== 2'd3) begin failures++; $display("FAIL both_ptr got=%0d exp=3", ptr); end
        offer(4'b0000, 4'd5);
        checks++; if (req_ready !== 1'b1 || gnt_valid !== 1'b0 || ptr !== 2'd3) begin failures++; $display("FAIL zero_req rdy=%b v=%b ptr=%0d exp 1/0/3", req_ready, gnt_valid, ptr); end
        acc = 1; cyc(); acc = 0;
        checks++; if (ptr !== 2'd3) begin failures++; $display("FAIL idle_acc_ptr got=%0d exp=3", ptr); end
    endtask

    task automatic test_reset_mid;
        offer(4'b1000, 4'd4);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rm_gnt got=%b exp=1000", gnt); end
        offer(4'b0001, 4'd2);
        checks++; if (gnt !== 4'b1000 || gnt_pri !== 4'd4) begin failures++; $display("FAIL rm_hold got=%b/%0d exp=1000/4", gnt, gnt_pri); end
        reset = 1; cyc(); reset = 0;
        checks++; if (gnt !== 4'b0000 || ptr !== 2'd0 || gnt_valid !== 1'b0) begin failures++; $display("FAIL rm_drop gnt=%b ptr=%0d v=%b exp 0000/0/0", gnt, ptr, gnt_valid); end
    endtask

    task automatic test_random;
        bit busy = 0, tp = 0;
        int k = 0, mptr = 0, waited = 0, bad = 0;
        logic [3:0] mpri = 0, latched = 0, eg;
        for (int c = 0; c < 10000; c++) begin
            req = 4'($urandom_range(0, 15));
            pri = 4'($urandom_range(0, P - 1));
            req_valid = $urandom_range(0, 1) == 1;
            acc = $urandom_range(0, 7) == 0;
            rej = $urandom_range(0, 7) == 0;
            cyc();
            tp = 0;
            if (!busy) begin
                if (req_valid && req != 0) begin
                    busy = 1; k = search(req, mptr); mpri = pri; latched = req; waited = 1;
                end
            end else if (acc) begin
                busy = 0; mptr = (k + 1) % N;
            end else if (rej) begin
                busy = 0;
            end else if (waited == TIMEOUT) begin
                busy = 0; tp = 1;
            end else begin
                waited++;
            end
            eg = busy ? 4'(1 << k) : 4'b0000;
            checks++;
            if (gnt !== eg || gnt_valid !== busy || ptr !== 2'(mptr) || timeout_pulse !== tp || req_ready !== !busy
                || (busy && gnt_pri !== mpri) || (gnt & ~latched) != 0 || !$onehot0(gnt)) begin
                failures++;
                if (bad++ < 10) $display("FAIL rand c=%0d gnt=%b/%b v=%b/%b ptr=%0d/%0d tp=%b/%b pri=%0d/%0d (got/exp)",
                    c, gnt, eg, gnt_valid, busy, ptr, mptr, timeout_pulse, tp, gnt_pri, mpri);
            end
        end
        acc = 0; rej = 0; req_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_search();
        test_timeout();
        test_acc_timeout();
        test_both_and_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
